// File: rtl/serial_tx_arbiter.sv
// serial_tx_arbiter
//   Shares one serial line between N_REQ word sources. A round-robin pointer
//   picks the next requester, its DATA_BITS word is latched on the grant edge
//   and shifted out one bit per clock in the receiver frame format:
//   start 0, data LSB-first, odd parity, stop 0, then IDLE_GAP idle-high cycles.
//
// Ports
//   Clk     : clock, all state changes on the rising edge
//   nReset  : asynchronous active-low reset
//   Req     : per-source request level, held until granted
//   Din     : packed words, source i at [i*DATA_BITS +: DATA_BITS]
//   Grant   : one-hot, one-cycle pulse when a source's word is latched
//   Owner   : index of the source whose frame is on Q (holds after Busy falls)
//   Busy    : high from the start bit through the last gap cycle
//   Q       : registered serial line, idles high
module serial_tx_arbiter #(
  parameter int N_REQ     = 4,
  parameter int DATA_BITS = 6,
  parameter int IDLE_GAP  = 1,
  parameter int OWNER_W   = 2
) (
  input  logic                         Clk,
  input  logic                         nReset,
  input  logic [N_REQ-1:0]             Req,
  input  logic [N_REQ*DATA_BITS-1:0]   Din,
  output logic [N_REQ-1:0]             Grant,
  output logic [OWNER_W-1:0]           Owner,
  output logic                         Busy,
  output logic                         Q
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // The start bit is launched on the grant edge itself, so START is never
  // occupied; it only exists as a named encoding and recovers to IDLE.
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, GAP} state_t;

  state_t               state_q, state_d;
  logic [IDX_W-1:0]     ptr_q, ptr_d;
  logic [OWNER_W-1:0]   owner_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic [BIT_W-1:0]     bit_q, bit_d;
  logic [3:0]           gap_q, gap_d;
  logic [N_REQ-1:0]     grant_d;
  logic                 busy_d, q_d;

  logic                 win_found;
  logic [IDX_W-1:0]     win_idx;
  logic [IDX_W-1:0]     cand_idx;
  int                   cand;

  // Round-robin search: first set Req at or after the pointer, wrapping
  // from N_REQ-1 back to 0.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= N_REQ) cand = cand - N_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && Req[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    owner_d = Owner;
    shift_d = shift_q;
    par_d   = par_q;
    bit_d   = bit_q;
    gap_d   = gap_q;
    grant_d = '0;
    busy_d  = Busy;
    q_d     = 1'b1;
    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (win_found) begin
          shift_d = Din[win_idx*DATA_BITS +: DATA_BITS];
          par_d   = ~^Din[win_idx*DATA_BITS +: DATA_BITS];
          grant_d = N_REQ'(1) << win_idx;
          owner_d = OWNER_W'(win_idx);
          ptr_d   = (win_idx == IDX_W'(N_REQ-1)) ? '0 : win_idx + 1'b1;
          bit_d   = '0;
          q_d     = 1'b0;
          busy_d  = 1'b1;
          state_d = DATA;
        end
      end
      DATA: begin
        q_d     = shift_q[0];
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 1'b1;
        if (bit_q == BIT_W'(DATA_BITS-1)) state_d = PARITY;
      end
      PARITY: begin
        q_d     = par_q;
        state_d = STOP;
      end
      STOP: begin
        q_d     = 1'b0;
        gap_d   = 4'(IDLE_GAP);
        state_d = GAP;
      end
      GAP: begin
        // Busy stays high here; it drops on the following IDLE edge unless a
        // pending request starts the next frame back-to-back.
        q_d   = 1'b1;
        gap_d = gap_q - 1'b1;
        if (gap_q <= 4'd1) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      Owner   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      bit_q   <= '0;
      gap_q   <= '0;
      Grant   <= '0;
      Busy    <= 1'b0;
      Q       <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      Owner   <= owner_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      bit_q   <= bit_d;
      gap_q   <= gap_d;
      Grant   <= grant_d;
      Busy    <= busy_d;
      Q       <= q_d;
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Testbench for serial_tx_arbiter: table of single-frame transactions, a
// back-to-back burst, mid-frame reset and mid-frame request sequences. A
// frame monitor pops the expected source/word from a scoreboard on each Grant
// and decodes the line like the team's receiver (Dout, Error).
module tb_serial_tx_arbiter;
  localparam int N_REQ     = 4;
  localparam int DATA_BITS = 6;
  localparam int IDLE_GAP  = 1;
  localparam int OWNER_W   = 2;
  localparam int FRAME_LEN = DATA_BITS + 3 + IDLE_GAP;
  localparam logic [23:0] DIN_DEF = {6'h38, 6'h27, 6'h12, 6'h2D};

  logic        Clk = 1'b0;
  logic        nReset = 1'b0;
  logic [3:0]  Req = '0;
  logic [23:0] Din = '0;
  logic [3:0]  Grant;
  logic [1:0]  Owner;
  logic        Busy;
  logic        Q;

  serial_tx_arbiter #(
    .N_REQ(N_REQ), .DATA_BITS(DATA_BITS), .IDLE_GAP(IDLE_GAP), .OWNER_W(OWNER_W)
  ) dut (
    .Clk(Clk), .nReset(nReset), .Req(Req), .Din(Din),
    .Grant(Grant), .Owner(Owner), .Busy(Busy), .Q(Q)
  );

  always #5 Clk = ~Clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int         owner;
    logic [5:0] word;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0]  req;
    logic [23:0] din;
    int          exp_owner;
    logic        exp_par;
  } vec_t;
  vec_t tbl[9];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  // Frame monitor and receiver model
  exp_t       cur;
  int         mon_cnt = 0;
  logic [5:0] rx_data = '0;
  logic       rx_par = 1'b0;
  logic       rx_stop = 1'b0;
  logic       rx_err;
  logic       last_par = 1'b0;

  always @(negedge Clk) begin
    if (!nReset) begin
      mon_cnt = 0;
    end else if (mon_cnt == 0) begin
      if (Grant != 4'b0000) begin
        if (sb.size() == 0) begin
          chk("unexpected_grant", 32'(Grant), 32'd0);
        end else begin
          cur = sb.pop_front();
          chk("grant_onehot", 32'(Grant), 32'd1 << cur.owner);
          chk("owner", 32'(Owner), 32'(cur.owner));
          chk("start_bit", 32'(Q), 32'd0);
          chk("busy_start", 32'(Busy), 32'd1);
          mon_cnt = 1;
        end
      end
    end else begin
      chk("grant_pulse", 32'(Grant), 32'd0);
      chk("busy_frame", 32'(Busy), 32'd1);
      if (mon_cnt <= DATA_BITS) begin
        rx_data[mon_cnt-1] = Q;
      end else if (mon_cnt == DATA_BITS + 1) begin
        rx_par = Q;
        last_par = Q;
      end else if (mon_cnt == DATA_BITS + 2) begin
        rx_stop = Q;
        rx_err = (^{rx_data, rx_par} != 1'b1) || rx_stop;
        chk("rx_dout", 32'(rx_data), 32'(cur.word));
        chk("rx_error", 32'(rx_err), 32'd0);
        chk("parity_bit", 32'(rx_par), 32'(~^cur.word));
      end else begin
        chk("gap_bit", 32'(Q), 32'd1);
      end
      mon_cnt = (mon_cnt == FRAME_LEN - 1) ? 0 : mon_cnt + 1;
    end
  end

  task automatic wait_grant(output int n);
    n = 0;
    do begin
      @(negedge Clk);
      n++;
    end while (Grant == 4'b0000 && n < 30);
    if (Grant == 4'b0000) chk("grant_timeout", 32'(n), 32'd0);
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (Busy && n < 40) begin
      @(negedge Clk);
      n++;
    end
    if (Busy) chk("idle_timeout", 32'(n), 32'd0);
  endtask

  task automatic push_exp(input int owner, input logic [23:0] din);
    exp_t e;
    e.owner = owner;
    e.word  = din[owner*DATA_BITS +: DATA_BITS];
    sb.push_back(e);
  endtask

  initial begin
    int n;
    int bad;
    logic [23:0] burst;

    tbl[0] = '{4'b0001, DIN_DEF, 0, 1'b1};
    tbl[1] = '{4'b0010, DIN_DEF, 1, 1'b1};
    tbl[2] = '{4'b0011, DIN_DEF, 0, 1'b1};
    tbl[3] = '{4'b0110, DIN_DEF, 1, 1'b1};
    tbl[4] = '{4'b0001, {6'h38, 6'h27, 6'h12, 6'h00}, 0, 1'b1};
    tbl[5] = '{4'b0100, {6'h38, 6'h3F, 6'h12, 6'h2D}, 2, 1'b1};
    tbl[6] = '{4'b1000, {6'h01, 6'h27, 6'h12, 6'h2D}, 3, 1'b0};
    tbl[7] = '{4'b1010, DIN_DEF, 1, 1'b1};
    tbl[8] = '{4'b1001, DIN_DEF, 3, 1'b0};

    // Reset state
    @(negedge Clk);
    chk("rst_q", 32'(Q), 32'd1);
    chk("rst_grant", 32'(Grant), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_owner", 32'(Owner), 32'd0);
    #2 nReset = 1'b1;
    @(negedge Clk);

    // Single-frame table: latency, frame length, Owner hold, parity
    for (int i = 0; i < 9; i++) begin
      push_exp(tbl[i].exp_owner, tbl[i].din);
      Din = tbl[i].din;
      Req = tbl[i].req;
      wait_grant(n);
      chk("latency", 32'(n), 32'd1);
      Req = '0;
      Din = ~Din;
      wait_idle(n);
      chk("busy_len", 32'(n), 32'(FRAME_LEN));
      chk("owner_hold", 32'(Owner), 32'(tbl[i].exp_owner));
      chk("parity_tbl", 32'(last_par), 32'(tbl[i].exp_par));
    end

    // Back-to-back burst, all sources requesting, pointer at 0
    burst = {6'h15, 6'h2A, 6'h0F, 6'h33};
    Din = burst;
    push_exp(0, burst); push_exp(1, burst); push_exp(2, burst);
    push_exp(3, burst); push_exp(0, burst);
    Req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      wait_grant(n);
      if (k == 0) chk("burst_latency", 32'(n), 32'd1);
      else        chk("burst_spacing", 32'(n), 32'(FRAME_LEN));
    end
    Req = '0;
    wait_idle(n);
    chk("burst_owner_hold", 32'(Owner), 32'd0);

    // Reset during the third data bit (pointer is 1 here)
    Din = DIN_DEF;
    push_exp(1, DIN_DEF);
    Req = 4'b0010;
    wait_grant(n);
    Req = '0;
    repeat (3) @(negedge Clk);
    chk("bit2_before_reset", 32'(Q), 32'(DIN_DEF[6+2]));
    #2 nReset = 1'b0;
    #1;
    chk("async_rst_q", 32'(Q), 32'd1);
    chk("async_rst_busy", 32'(Busy), 32'd0);
    chk("async_rst_grant", 32'(Grant), 32'd0);
    chk("async_rst_owner", 32'(Owner), 32'd0);
    @(negedge Clk);
    push_exp(2, DIN_DEF);
    Req = 4'b0100;
    #2 nReset = 1'b1;
    wait_grant(n);
    chk("post_rst_latency", 32'(n), 32'd1);
    Req = '0;
    wait_idle(n);
    chk("post_rst_owner", 32'(Owner), 32'd2);

    // Idle reset must return the pointer to 0: Req 1001 then picks source 0
    @(negedge Clk);
    #2 nReset = 1'b0;
    @(negedge Clk);
    push_exp(0, DIN_DEF);
    Req = 4'b1001;
    #2 nReset = 1'b1;
    wait_grant(n);
    Req = '0;
    wait_idle(n);
    chk("ptr_reset_owner", 32'(Owner), 32'd0);

    // Request rising and falling mid-frame leaves nothing behind
    push_exp(0, DIN_DEF);
    Req = 4'b0001;
    wait_grant(n);
    Req = '0;
    repeat (3) @(negedge Clk);
    Req = 4'b1000;
    repeat (4) @(negedge Clk);
    Req = '0;
    wait_idle(n);
    bad = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge Clk);
      if (Q !== 1'b1 || Grant !== 4'b0000 || Busy !== 1'b0) bad++;
    end
    chk("quiet_after_withdraw", 32'(bad), 32'd0);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got=%0t expected=finish", $time);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/serial_tx_arbiter.md
Name: serial_tx_arbiter

Overview:
- Shares one serial line between N_REQ word sources.
- Selects a requester round-robin, latches its DATA_BITS word and serializes it, one bit per Clk, in the team's receiver frame format: start 0, data LSB-first, odd parity, stop 0.
- Sits on the transmit side and drives the D input of the team's asynchronous receiver directly.

Parameters:
N_REQ, 4, number of requesters
DATA_BITS, 6, data bits per frame
IDLE_GAP, 1, minimum idle cycles (Q=1) after each stop bit; legal range 1..15
OWNER_W, 2, width of Owner; must be at least clog2(N_REQ)

Ports:
Clk  input  1  clock, all state updates on rising edge
nReset  input  1  asynchronous active-low reset
Req  input  N_REQ  request per source; level, held until granted
Din  input  N_REQ*DATA_BITS  packed words; source i occupies bits [i*DATA_BITS +: DATA_BITS]
Grant  output  N_REQ  one-hot, one-cycle pulse when a source's word is latched
Owner  output  OWNER_W  index of the source whose frame is on Q; valid while Busy
Busy  output  1  high from the start bit through the last gap cycle
Q  output  1  registered serial line; idles high

Behaviour:
- Reset, asynchronous on nReset low:
  - Q=1, Grant=0, Busy=0, Owner=0.
  - Round-robin pointer=0, state=IDLE, shift register and counters cleared.
  - Reset in mid-frame abandons the frame immediately; the line goes to 1 and the partial frame is never resent.
- States: IDLE, START, DATA, PARITY, STOP, GAP.
- IDLE:
  - Q=1, Busy=0.
  - At an edge with any Req high, the winner is the first set Req at or after the pointer, searching upward with wrap from N_REQ-1 to 0.
  - On that edge: latch the winner's Din word, Grant<=onehot(winner), Owner<=winner, pointer<=winner+1 (mod N_REQ), Q<=0 (start bit), Busy<=1, go to DATA.
  - The latched parity is ~^word, so data plus parity has an odd number of ones.
  - Latency is one edge from Req sampled to the start bit on Q.
- Grant falls on the next edge. Sources may change Din or drop Req from the cycle after Grant.
- Din of the winner is sampled only on the grant edge. Req is never re-sampled until IDLE.
- DATA: DATA_BITS edges; each drives Q<=word[k] for k=0..DATA_BITS-1, then go to PARITY.
- PARITY: Q<=parity, go to STOP.
- STOP: Q<=0, go to GAP with the gap counter loaded to IDLE_GAP.
- GAP:
  - Q<=1, decrement the counter, Busy stays 1.
  - When the counter reaches 1, go to IDLE, where Busy<=0 on the transition edge.
  - Total line occupancy per frame is exactly DATA_BITS+3+IDLE_GAP cycles, 10 at defaults.
- Requests that arrive or drop while Busy are ignored until IDLE.
- Back-to-back: if Req is pending in IDLE, the next start bit follows the last gap cycle with no extra idle cycle.
- Req withdrawn before its grant leaves no state.
- Simultaneous requests are resolved only by the pointer; there is no fixed priority.
- Owner holds its value after Busy falls until the next grant.
- No combinational path from any input to Q, Grant, Owner or Busy.

Test Plan:
1. Reset then Req=4'b0001, Din[5:0]=6'b101101 → Grant=0001 for one cycle; Q sequence from the grant edge is 0,1,0,1,1,0,1,1,0, then 1 for IDLE_GAP cycles; Busy high for exactly 10 cycles; Owner=0.
2. Req=4'b1111 held continuously with distinct words → grants in order 0,1,2,3,0, spaced exactly 10 cycles apart; each frame carries its own source's word and its parity.
3. Pointer=2 (after granting source 1), Req=4'b0011 → source 0 granted (wrap); then Req=4'b0110 from pointer 1 → source 1 granted.
4. Parity boundaries: word 6'b000000 → parity bit 1; word 6'b111111 → parity bit 1; word 6'b000001 → parity bit 0.
5. nReset pulsed low during the third data bit → Q=1, Busy=0 and Grant=0 asynchronously. Pending Req=4'b0100 after release → grant to source 2 with pointer at 0; full frame correct.
6. Req[3] rises mid-frame and falls before IDLE → no grant and no line activity. Check against the receiver model that frames from scenarios 1 and 2 give matching Dout and Error=0.
